// File: rtl/rtlola_input_queue.sv
// Timestamped input event queue feeding the RTLola evaluator.
// Merges x events with periodic deadlines into a FWFT FIFO.
module rtlola_input_queue #(
    parameter int DATA_W = 64,
    parameter int TS_W   = 64,
    parameter int DEPTH  = 4,
    parameter int PERIOD = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic signed [DATA_W-1:0]        in_x,
    input  logic                            in_new,
    input  logic                            pop,
    output logic                            out_valid,
    output logic signed [DATA_W-1:0]        out_x,
    output logic                            out_new_x,
    output logic                            out_tick,
    output logic [TS_W-1:0]                 out_ts,
    output logic                            push_valid,
    output logic                            pop_valid,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(PERIOD);

    logic [TS_W-1:0]          r_ts;
    logic [PW-1:0]            r_tick;
    logic [AW-1:0]            r_rd;
    logic [AW-1:0]            r_wr;
    logic [CW-1:0]            r_count;
    logic                     r_ovf;
    logic                     r_push_v;
    logic                     r_pop_v;

    logic signed [DATA_W-1:0] r_mem_x    [DEPTH];
    logic                     r_mem_new  [DEPTH];
    logic                     r_mem_tick [DEPTH];
    logic [TS_W-1:0]          r_mem_ts   [DEPTH];

    logic                     w_deadline;
    logic                     w_cand;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic signed [DATA_W-1:0] w_cand_x;

    assign w_deadline = (r_tick == PW'(PERIOD - 1));
    assign w_cand     = en && (in_new || w_deadline);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_pop      = en && pop && !w_empty;
    // A full queue still accepts when the head leaves on the same edge
    assign w_push     = w_cand && (!w_full || w_pop);
    assign w_cand_x   = in_new ? in_x : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts     <= '0;
            r_tick   <= '0;
            r_rd     <= '0;
            r_wr     <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_push_v <= 1'b0;
            r_pop_v  <= 1'b0;
        end else begin
            r_push_v <= w_push;
            r_pop_v  <= w_pop;
            if (en) begin
                r_ts   <= r_ts + 1'b1;
                r_tick <= w_deadline ? '0 : r_tick + 1'b1;
            end
            if (w_cand && !w_push) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_x[r_wr]    <= w_cand_x;
            r_mem_new[r_wr]  <= in_new;
            r_mem_tick[r_wr] <= w_deadline;
            r_mem_ts[r_wr]   <= r_ts;
        end
    end

    // Head fields are masked while empty so stale storage never leaks out
    always_comb begin
        out_valid = !w_empty;
        out_x     = '0;
        out_new_x = 1'b0;
        out_tick  = 1'b0;
        out_ts    = '0;
        if (!w_empty) begin
            out_x     = r_mem_x[r_rd];
            out_new_x = r_mem_new[r_rd];
            out_tick  = r_mem_tick[r_rd];
            out_ts    = r_mem_ts[r_rd];
        end
    end

    assign push_valid = r_push_v;
    assign pop_valid  = r_pop_v;
    assign count      = r_count;
    assign overflow   = r_ovf;
endmodule

// File: tb/tb_rtlola_input_queue.sv
// Self-checking bench for rtlola_input_queue.
// Directed scenarios plus random traffic against a queue model.
module tb_rtlola_input_queue;
    localparam int DW = 64;
    localparam int TW = 64;
    localparam int D  = 4;
    localparam int P  = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b0;
    logic signed [DW-1:0] in_x = '0;
    logic                 in_new = 1'b0;
    logic                 pop = 1'b0;
    logic                 out_valid;
    logic signed [DW-1:0] out_x;
    logic                 out_new_x;
    logic                 out_tick;
    logic [TW-1:0]        out_ts;
    logic                 push_valid;
    logic                 pop_valid;
    logic [$clog2(D):0]   count;
    logic                 overflow;

    rtlola_input_queue #(
        .DATA_W(DW), .TS_W(TW), .DEPTH(D), .PERIOD(P)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_x(in_x), .in_new(in_new), .pop(pop),
        .out_valid(out_valid), .out_x(out_x),
        .out_new_x(out_new_x), .out_tick(out_tick),
        .out_ts(out_ts), .push_valid(push_valid),
        .pop_valid(pop_valid), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] x;
        bit          nw;
        bit          tk;
        logic [63:0] ts;
    } ent_t;

    ent_t        m_q[$];
    logic [63:0] m_ts;
    bit          m_ovf;
    bit          m_pv;
    bit          m_ppv;

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit v;
        v = (m_q.size() > 0);
        chk("valid", 64'(out_valid), 64'(v));
        chk("x", out_x, v ? m_q[0].x : 64'd0);
        chk("new", 64'(out_new_x), v ? 64'(m_q[0].nw) : 64'd0);
        chk("tick", 64'(out_tick), v ? 64'(m_q[0].tk) : 64'd0);
        chk("ts", out_ts, v ? m_q[0].ts : 64'd0);
        chk("push_v", 64'(push_valid), 64'(m_pv));
        chk("pop_v", 64'(pop_valid), 64'(m_ppv));
        chk("count", 64'(count), 64'(m_q.size()));
        chk("ovf", 64'(overflow), 64'(m_ovf));
    endtask

    task automatic model_edge(input bit r, input bit e, input bit n,
                              input logic [63:0] x, input bit p);
        bit dl, cand, pa, pu;
        ent_t en_t;
        if (r) begin
            m_q.delete();
            m_ts = 0; m_ovf = 0; m_pv = 0; m_ppv = 0;
        end else if (e) begin
            dl   = ((m_ts % P) == P - 1);
            cand = n || dl;
            pa   = p && (m_q.size() > 0);
            pu   = cand && ((m_q.size() < D) || pa);
            if (pa) void'(m_q.pop_front());
            if (pu) begin
                en_t.x  = n ? x : 64'd0;
                en_t.nw = n;
                en_t.tk = dl;
                en_t.ts = m_ts;
                m_q.push_back(en_t);
            end
            if (cand && !pu) m_ovf = 1;
            m_pv = pu; m_ppv = pa;
            m_ts = m_ts + 1;
        end else begin
            m_pv = 0; m_ppv = 0;
        end
    endtask

    task automatic cyc(input bit e, input bit n,
                       input logic [63:0] x, input bit p,
                       input bit r = 0);
        rst = r; en = e; in_new = n; in_x = x; pop = p;
        @(posedge clk);
        model_edge(r, e, n, x, p);
        #1;
        check_all();
    endtask

    logic [63:0] pre_ts;

    initial begin
        m_ts = 0; m_ovf = 0; m_pv = 0; m_ppv = 0;
        // Reset state
        cyc(0, 0, 0, 0, 1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);

        // Enqueue and hold
        for (int i = 1; i <= 4; i++) cyc(1, 1, 64'(i), 0);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_x", out_x, 64'd1);
        chk("fill_ts", out_ts, 64'd0);
        chk("fill_ovf", 64'(overflow), 64'd0);
        cyc(1, 1, 64'd5, 0);
        chk("drop_ovf", 64'(overflow), 64'd1);
        chk("drop_count", 64'(count), 64'd4);
        // Pops at ts 5..8; ts 7 also raises a deadline entry
        cyc(1, 0, 0, 1);
        chk("pop1_x", out_x, 64'd2);
        chk("pop1_ts", out_ts, 64'd1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("dl_tick", 64'(out_tick), 64'd1);
        chk("dl_x", out_x, 64'd0);
        chk("dl_ts", out_ts, 64'd7);
        cyc(1, 0, 0, 1);
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_x", out_x, 64'd0);

        // Pop while empty, then push 6
        cyc(1, 0, 0, 1);
        chk("epop_pv", 64'(pop_valid), 64'd0);
        chk("epop_cnt", 64'(count), 64'd0);
        cyc(1, 1, 64'd6, 0);
        chk("after_epop_x", out_x, 64'd6);

        // Full plus simultaneous push/pop
        cyc(0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) cyc(1, 1, 64'(i), 0);
        cyc(1, 1, 64'd5, 1);
        chk("fpp_count", 64'(count), 64'd4);
        chk("fpp_x", out_x, 64'd2);
        chk("fpp_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1);

        // Periodic deadlines with a merged event at ts 15
        cyc(0, 0, 0, 0, 1);
        for (int c = 0; c < 25; c++) begin
            cyc(1, c == 15, (c == 15) ? 64'd9 : 64'd0,
                m_q.size() > 0);
            if (c == 7 || c == 23) begin
                chk("per_tick", 64'(out_tick), 64'd1);
                chk("per_ts", out_ts, 64'(c));
            end
            if (c == 15) begin
                chk("merge_x", out_x, 64'd9);
                chk("merge_new", 64'(out_new_x), 64'd1);
                chk("merge_tick", 64'(out_tick), 64'd1);
            end
        end

        // Enable gating
        for (int i = 0; i < 8 && m_q.size() > 0; i++) cyc(1, 0, 0, 1);
        pre_ts = m_ts - 1;
        for (int i = 0; i < 5; i++) cyc(0, 1, 64'd77, 0);
        chk("gap_count", 64'(count), 64'd0);
        cyc(1, 1, 64'd11, 0);
        chk("gap_ts", out_ts, pre_ts + 1);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) cyc(1, 1, 64'(20 + i), 0);
        cyc(1, 0, 0, 1);
        chk("pre_rst_ovf", 64'(overflow), 64'd1);
        cyc(1, 0, 0, 0, 1);
        chk("mid_rst_cnt", 64'(count), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        cyc(1, 1, 64'd42, 0);
        chk("post_rst_ts", out_ts, 64'd0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 7) != 0,
                $urandom_range(0, 1) == 1,
                {$urandom, $urandom},
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 63) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/rtlola_input_queue.md
# rtlola_input_queue

Timestamped input event queue that sits directly upstream of the RTLola monitor evaluator. It captures input-stream events (`x` value plus new-value flag), merges them with internally generated periodic deadlines, and buffers them in order. The evaluator then drains the entries one at a time. Outputs are first-word-fall-through and match the evaluator's `qPush`/`qPop`/`qOutX`/`qOutNewX` debug view.

## Interface
Parameters:
- `DATA_W`, 64: width of signed input value `x`.
- `TS_W`, 64: timestamp width in clock cycles.
- `DEPTH`, 4: queue entries; a power of two, ≥2.
- `PERIOD`, 8: cycles between periodic deadlines; ≥2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  global enable; when 0 all state holds.
- `in_x`  in  DATA_W  signed input value.
- `in_new`  in  1  `in_x` carries a new event this cycle.
- `pop`  in  1  evaluator consumes head entry this cycle.
- `out_valid`  out  1  head entry present (queue not empty).
- `out_x`  out  DATA_W  head value; 0 when empty.
- `out_new_x`  out  1  head carries an `x` event; 0 when empty.
- `out_tick`  out  1  head carries a periodic deadline; 0 when empty.
- `out_ts`  out  TS_W  head capture timestamp; 0 when empty.
- `push_valid`  out  1  registered: an entry was enqueued on the previous enabled edge.
- `pop_valid`  out  1  registered: an entry was dequeued on the previous enabled edge.
- `count`  out  clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky; an entry was dropped.

## Operation
- `ts` counts enabled cycles. The first enabled cycle after reset has `ts`=0. It wraps modulo 2^TS_W.
- The tick counter runs 0..PERIOD-1 on enabled cycles. A deadline is asserted in the cycle where the counter equals PERIOD-1, so the first deadline is at `ts`=PERIOD-1. The counter then returns to 0.
- Candidate entry each enabled cycle = {`in_x`, `in_new`, deadline, `ts`}. It exists only if `in_new` or deadline is set.
  - When both fire in the same cycle, they merge into one entry with both flags set.
  - A deadline-only entry stores `x`=0.
- Push is accepted if `count`<DEPTH, or if `count`==DEPTH and an accepted pop occurs in the same cycle.
  - Otherwise the candidate is dropped and `overflow` is set; it clears only on reset.
- Pop is accepted only if `out_valid`=1. A pop while empty is ignored; `pop_valid` stays 0 and no state changes.
- When the queue is empty, a same-cycle push and pop gives: pop ignored, push accepted.
- `count` update per cycle: +1 for push only, −1 for pop only, unchanged for both.
- Read and write pointers wrap modulo DEPTH. Ordering is strict FIFO.
- `en`=0:
  - no capture, no push, no pop;
  - `ts` and the tick counter hold;
  - `push_valid` and `pop_valid` go to 0;
  - head outputs keep showing the current head.
- Reset:
  - clears `ts`, the tick counter, pointers, `count`, `overflow`, `push_valid` and `pop_valid`;
  - flushes the queue and drives all outputs to 0;
  - a reset mid-operation discards buffered entries.

## Timing
- A push accepted on edge t is visible on `out_*` after edge t (zero-wait FWFT from registered storage). `push_valid`=1 in the same cycle.
- Pop is combinational-acknowledged. The head advances on the same edge, and the next entry appears immediately after it.
- Minimum in-to-out latency is 1 cycle. Sustained throughput is 1 entry/cycle with continuous pop.
- The head is always the oldest entry. `out_*` derive only from storage and the read pointer, with no combinational path from `in_*`.
- After `rst` deasserts, the first enabled cycle has `ts`=0.

## Test plan
- Enqueue and hold (DEPTH=4, PERIOD=100, no pop): `in_x`=1,2,3,4 with `in_new`=1 on 4 consecutive cycles.
  - Expect `count`=4, `out_x`=1, `out_ts`=0, `overflow`=0.
  - A fifth event `x`=5 is dropped and `overflow`=1.
  - Then pop ×4 yields 1,2,3,4 with `out_ts` 0,1,2,3; afterwards `out_valid`=0 and `out_x`=0.
- Full plus simultaneous push/pop: fill with 1..4, then push 5 with `pop`=1.
  - Expect `count` stays 4, head becomes 2, `overflow`=0.
  - Draining gives 2,3,4,5.
- Periodic deadlines (PERIOD=8, no `in_new`, pop whenever valid):
  - deadline-only entries with `out_tick`=1, `out_x`=0, `out_ts`=7,15,23.
  - `in_new` with `x`=9 at `ts`=15 gives a single merged entry with both flags set and `out_x`=9.
- Pop while empty: `pop`=1 with the queue empty gives `pop_valid`=0, `count`=0 and no pointer change. A subsequent push of 6 is seen at the head.
- Enable gating: hold `en`=0 for 5 cycles with `in_new`=1.
  - No entries are captured; `ts` and the tick phase are unchanged.
  - After `en`=1, the next entry's timestamp equals the pre-gap value +1.
- Reset mid-operation: with 3 entries queued and `overflow`=1, assert `rst` for 1 cycle.
  - All outputs read 0.
  - The next event gets `ts`=0 and the first deadline falls at `ts`=PERIOD-1.
